// File: rtl/c1541_gcr_pkg.sv
// Shared types, marker bytes, GCR inverse table and per-zone sector limits
// for the 1541 GCR read-path decoder.
package c1541_gcr_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_SYNC,
        ST_MARK,
        ST_HDR,
        ST_GAP,
        ST_DATA
    } gcr_state_e;

    localparam logic [7:0] MARK_HDR  = 8'h08;
    localparam logic [7:0] MARK_DATA = 8'h07;

    // Returns {valid, nibble}; codes with no entry map to nibble 0.
    function automatic logic [4:0] gcr_dec_tbl(input logic [4:0] code);
        case (code)
            5'h0A:   return {1'b1, 4'h0};
            5'h0B:   return {1'b1, 4'h1};
            5'h12:   return {1'b1, 4'h2};
            5'h13:   return {1'b1, 4'h3};
            5'h0E:   return {1'b1, 4'h4};
            5'h0F:   return {1'b1, 4'h5};
            5'h16:   return {1'b1, 4'h6};
            5'h17:   return {1'b1, 4'h7};
            5'h09:   return {1'b1, 4'h8};
            5'h19:   return {1'b1, 4'h9};
            5'h1A:   return {1'b1, 4'hA};
            5'h1B:   return {1'b1, 4'hB};
            5'h0D:   return {1'b1, 4'hC};
            5'h1D:   return {1'b1, 4'hD};
            5'h1E:   return {1'b1, 4'hE};
            5'h15:   return {1'b1, 4'hF};
            default: return {1'b0, 4'h0};
        endcase
    endfunction

    function automatic logic [4:0] sector_max(input logic [5:0] trk);
        if (trk < 6'd18)      return 5'd20;
        else if (trk < 6'd25) return 5'd18;
        else if (trk < 6'd31) return 5'd17;
        else                  return 5'd16;
    endfunction

endpackage

// File: rtl/c1541_gcr_nib_dec.sv
// One 5-bit GCR code to a 4-bit nibble, flagging codes outside the table.
module c1541_gcr_nib_dec
    import c1541_gcr_pkg::*;
(
    input  logic [4:0] code,
    output logic [3:0] nib,
    output logic       inv
);

    logic [4:0] ent;

    assign ent = gcr_dec_tbl(code);
    assign nib = ent[3:0];
    assign inv = !ent[4];

endmodule

// File: rtl/c1541_gcr_dec.sv
// 1541 GCR bitstream decoder: SYNC detect, byte framing, header/data parsing
// and sector-buffer writes. Define GCR_DEC_CKS_EN to enforce checksums.
module c1541_gcr_dec
    import c1541_gcr_pkg::*;
#(
    parameter int SYNC_MIN = 10,
    parameter int GAP_MAX  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bit_en,
    input  logic        bit_in,
    input  logic [5:0]  track,
    output logic        sync_n,
    output logic        byte_valid,
    output logic [7:0]  byte_out,
    output logic        buf_we,
    output logic [12:0] buf_addr,
    output logic [7:0]  buf_data,
    output logic        sec_done,
    output logic        data_ok,
    output logic        gcr_err
);

`ifdef GCR_DEC_CKS_EN
    localparam bit CKS_EN = 1'b1;
`else
    localparam bit CKS_EN = 1'b0;
`endif

    localparam int RUN_W = $clog2(SYNC_MIN + 1);
    localparam int GAP_W = $clog2(GAP_MAX + 1);
    localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(SYNC_MIN);
    localparam logic [GAP_W-1:0] GAP_LIM = GAP_W'(GAP_MAX);

    gcr_state_e       state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d, run_nxt;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [8:0]       shreg_q, shreg_d;
    logic [2:0]       hdr_cnt_q, hdr_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [7:0]       idx_q, idx_d;
    logic             at_cks_q, at_cks_d;
    logic [7:0]       xsum_q, xsum_d;
    logic [7:0]       hdr_cks_q, hdr_cks_d, hdr_sec_q, hdr_sec_d;
    logic [7:0]       hdr_trk_q, hdr_trk_d, hdr_id2_q, hdr_id2_d;
    logic             hdr_valid_q, hdr_valid_d;
    logic [5:0]       trk_q;
    logic             sync_n_q, sync_n_d;
    logic             byte_valid_q, byte_valid_d;
    logic [7:0]       byte_out_q, byte_out_d;
    logic             buf_we_q, buf_we_d;
    logic [12:0]      buf_addr_q, buf_addr_d;
    logic [7:0]       buf_data_q, buf_data_d;
    logic             sec_done_q, sec_done_d;
    logic             data_ok_q, data_ok_d;
    logic             gcr_err_q, gcr_err_d;

    logic [9:0]       group;
    logic [1:0][4:0]  codes;
    logic [1:0][3:0]  nibs;
    logic [1:0]       invs;
    logic [7:0]       dec_byte;
    logic             dec_inv, framed, sync_now, byte_done, trk_chg;
    logic             hdr_cks_ok, data_cks_ok;

    assign group = {shreg_q, bit_in};
    assign codes = group;

    for (genvar g = 0; g < 2; g++) begin : g_nib
        c1541_gcr_nib_dec u_nib (
            .code (codes[g]),
            .nib  (nibs[g]),
            .inv  (invs[g])
        );
    end

    assign dec_byte = nibs;
    assign dec_inv  = |invs;

    assign run_nxt   = !bit_in ? '0 : (run_q == RUN_SAT) ? run_q : run_q + RUN_W'(1);
    assign framed    = state_q inside {ST_MARK, ST_HDR, ST_GAP, ST_DATA};
    // A SYNC run wins over a group that completes on the same bit.
    assign sync_now  = bit_en && (run_nxt == RUN_SAT) && (state_q != ST_SYNC);
    assign byte_done = bit_en && framed && (bit_cnt_q == 4'd9) && !sync_now;
    assign trk_chg   = track != trk_q;

    assign hdr_cks_ok  = !CKS_EN || (hdr_cks_q == (hdr_sec_q ^ hdr_trk_q ^ hdr_id2_q ^ dec_byte));
    assign data_cks_ok = !CKS_EN || (xsum_q == dec_byte);

    always_comb begin
        state_d      = state_q;
        run_d        = run_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        hdr_cnt_d    = hdr_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        idx_d        = idx_q;
        at_cks_d     = at_cks_q;
        xsum_d       = xsum_q;
        hdr_cks_d    = hdr_cks_q;
        hdr_sec_d    = hdr_sec_q;
        hdr_trk_d    = hdr_trk_q;
        hdr_id2_d    = hdr_id2_q;
        hdr_valid_d  = hdr_valid_q;
        sync_n_d     = sync_n_q;
        byte_valid_d = 1'b0;
        byte_out_d   = byte_out_q;
        buf_we_d     = 1'b0;
        buf_addr_d   = buf_addr_q;
        buf_data_d   = buf_data_q;
        sec_done_d   = 1'b0;
        data_ok_d    = data_ok_q;
        gcr_err_d    = gcr_err_q;

        if (bit_en) begin
            run_d    = run_nxt;
            sync_n_d = (run_nxt != RUN_SAT);
            if (framed) begin
                shreg_d   = group[8:0];
                bit_cnt_d = (bit_cnt_q == 4'd9) ? 4'd0 : bit_cnt_q + 4'd1;
            end else if (state_q == ST_SYNC && !bit_in) begin
                // The 0 that ends SYNC is the first bit of the mark group.
                shreg_d   = '0;
                bit_cnt_d = 4'd1;
                state_d   = ST_MARK;
            end else begin
                bit_cnt_d = 4'd0;
            end
        end

        if (sync_now) begin
            state_d   = ST_SYNC;
            bit_cnt_d = 4'd0;
            gcr_err_d = 1'b0;
            if (state_q != ST_GAP) hdr_valid_d = 1'b0;
        end

        if (byte_done) begin
            byte_valid_d = 1'b1;
            byte_out_d   = dec_byte;
            if (dec_inv) gcr_err_d = 1'b1;
            case (state_q)
                ST_MARK: begin
                    if (dec_byte == MARK_HDR) begin
                        state_d   = ST_HDR;
                        hdr_cnt_d = '0;
                    end else if (dec_byte == MARK_DATA && hdr_valid_q) begin
                        state_d  = ST_DATA;
                        idx_d    = '0;
                        at_cks_d = 1'b0;
                        xsum_d   = '0;
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
                ST_HDR: begin
                    hdr_cnt_d = hdr_cnt_q + 3'd1;
                    case (hdr_cnt_q)
                        3'd0:    hdr_cks_d = dec_byte;
                        3'd1:    hdr_sec_d = dec_byte;
                        3'd2:    hdr_trk_d = dec_byte;
                        3'd3:    hdr_id2_d = dec_byte;
                        default: begin
                            hdr_valid_d = hdr_cks_ok && (hdr_trk_q == {2'b00, track})
                                          && (hdr_sec_q <= {3'b000, sector_max(track)});
                            state_d     = ST_GAP;
                            gap_cnt_d   = '0;
                        end
                    endcase
                end
                ST_GAP: begin
                    if (gap_cnt_q == GAP_LIM) begin
                        hdr_valid_d = 1'b0;
                        state_d     = ST_HUNT;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end
                ST_DATA: begin
                    if (!at_cks_q) begin
                        buf_we_d   = 1'b1;
                        buf_addr_d = {hdr_sec_q[4:0], idx_q};
                        buf_data_d = dec_byte;
                        xsum_d     = xsum_q ^ dec_byte;
                        if (idx_q == 8'hFF) at_cks_d = 1'b1;
                        else                idx_d    = idx_q + 8'd1;
                    end else begin
                        sec_done_d  = 1'b1;
                        data_ok_d   = data_cks_ok && !gcr_err_q && !dec_inv;
                        hdr_valid_d = 1'b0;
                        at_cks_d    = 1'b0;
                        idx_d       = '0;
                        state_d     = ST_HUNT;
                    end
                end
                default: ;
            endcase
        end

        if (trk_chg) begin
            state_d     = ST_HUNT;
            hdr_valid_d = 1'b0;
            buf_we_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_HUNT;
            run_q        <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            hdr_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            idx_q        <= '0;
            at_cks_q     <= 1'b0;
            xsum_q       <= '0;
            hdr_cks_q    <= '0;
            hdr_sec_q    <= '0;
            hdr_trk_q    <= '0;
            hdr_id2_q    <= '0;
            hdr_valid_q  <= 1'b0;
            trk_q        <= track;
            sync_n_q     <= 1'b1;
            byte_valid_q <= 1'b0;
            byte_out_q   <= '0;
            buf_we_q     <= 1'b0;
            buf_addr_q   <= '0;
            buf_data_q   <= '0;
            sec_done_q   <= 1'b0;
            data_ok_q    <= 1'b0;
            gcr_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            hdr_cnt_q    <= hdr_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            idx_q        <= idx_d;
            at_cks_q     <= at_cks_d;
            xsum_q       <= xsum_d;
            hdr_cks_q    <= hdr_cks_d;
            hdr_sec_q    <= hdr_sec_d;
            hdr_trk_q    <= hdr_trk_d;
            hdr_id2_q    <= hdr_id2_d;
            hdr_valid_q  <= hdr_valid_d;
            trk_q        <= track;
            sync_n_q     <= sync_n_d;
            byte_valid_q <= byte_valid_d;
            byte_out_q   <= byte_out_d;
            buf_we_q     <= buf_we_d;
            buf_addr_q   <= buf_addr_d;
            buf_data_q   <= buf_data_d;
            sec_done_q   <= sec_done_d;
            data_ok_q    <= data_ok_d;
            gcr_err_q    <= gcr_err_d;
        end
    end

    assign sync_n     = sync_n_q;
    assign byte_valid = byte_valid_q;
    assign byte_out   = byte_out_q;
    // Reset blocks a pending write in the very cycle it is raised.
    assign buf_we     = buf_we_q && !reset;
    assign buf_addr   = buf_addr_q;
    assign buf_data   = buf_data_q;
    assign sec_done   = sec_done_q;
    assign data_ok    = data_ok_q;
    assign gcr_err    = gcr_err_q;

endmodule

// File: doc/c1541_gcr_dec.md
C1541_GCR_DEC -- requirements
Module: c1541_gcr_dec

Interface
REQ-001 SHALL have parameter SYNC_MIN, default 10, meaning the number of consecutive 1 bits that qualify as SYNC.
REQ-002 SHALL have parameter GAP_MAX, default 64, meaning the maximum decoded bytes allowed between header end and data-block SYNC.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 bit_en  in  1  single-cycle strobe qualifying bit_in.
REQ-007 bit_in  in  1  raw GCR bit from head, MSB-first.
REQ-008 track  in  6  current track (1..35), compared against header.
REQ-009 sync_n  out  1  low while inside a SYNC run.
REQ-010 byte_valid  out  1  one-cycle pulse, decoded byte present.
REQ-011 byte_out  out  8  decoded byte.
REQ-012 buf_we, buf_addr[12:0], buf_data[7:0]  out  sector-buffer write port, with buf_addr = {sector[4:0], index[7:0]}.
REQ-013 sec_done  out  1  one-cycle pulse at the end of a data block.
REQ-014 data_ok  out  1  status of the last data block, valid with sec_done.
REQ-015 gcr_err  out  1  sticky invalid-code flag, cleared by SYNC.

Function
REQ-016 SHALL act only on cycles with bit_en=1; all other state SHALL hold.
REQ-017 SHALL count consecutive 1s. At count>=SYNC_MIN, sync_n SHALL be 0. The first 0 bit after the run SHALL end SYNC and become bit 0 of the first group.
REQ-018 SHALL decode each 10-bit group as two 5-bit codes (high nibble first) using the inverse 1541 GCR table. A code with no entry SHALL decode as 0 and set gcr_err.
REQ-019 byte_valid and byte_out SHALL be asserted in the cycle after the bit_en that completes the 10th bit.
REQ-020 States: HUNT, SYNC, MARK, HDR, GAP, DATA.
- HUNT -> SYNC on run>=SYNC_MIN.
- SYNC -> MARK on the first 0 bit.
REQ-021 MARK transitions:
- byte 0x08 -> HDR.
- byte 0x07 with hdr_valid -> DATA.
- any other byte -> HUNT.
REQ-022 HDR SHALL capture cks, sector, track, id2, id1 (5 bytes).
- hdr_valid = cks == sector^track^id2^id1, header track == track input, and sector <= sector_max(track).
- sector_max(track): 20 for track<18, 18 for track<25, 17 for track<31, else 16.
- Then -> GAP.
REQ-023 GAP: any SYNC -> SYNC. More than GAP_MAX bytes without SYNC SHALL clear hdr_valid and go to HUNT.
REQ-024 DATA SHALL write bytes 0..255 to buf_addr {sector, idx} with buf_we asserted together with byte_valid.
- Byte 256 is the checksum. data_ok = (XOR of 256 bytes == cks) and no gcr_err.
- sec_done pulses with the checksum byte_valid.
- hdr_valid SHALL then clear and the state -> HUNT.
REQ-025 A SYNC run detected in any state other than HUNT SHALL abort the current block without sec_done and go to SYNC. hdr_valid SHALL survive only if the state was GAP.
REQ-026 The index counter SHALL be 8 bits and SHALL NOT wrap into the checksum slot; no write SHALL occur at index 256.
REQ-027 A change of the track input SHALL clear hdr_valid in the next cycle and force HUNT.

Reset
REQ-028 reset SHALL force:
- state = HUNT, all counters = 0, hdr_valid = 0;
- sync_n = 1, byte_valid = 0, byte_out = 0, buf_we = 0, buf_addr = 0, buf_data = 0, sec_done = 0, data_ok = 0, gcr_err = 0.
REQ-029 reset mid-DATA SHALL suppress any further buf_we in the same cycle.

Configuration
REQ-030 Macro GCR_DEC_CKS_EN:
- Defined: header and data checksums are checked as above.
- Undefined: checksum comparisons are treated as always true, and data_ok reflects only gcr_err.

Structure
REQ-031 Package c1541_gcr_pkg SHALL hold the state enum, marker constants (0x08, 0x07), the GCR decode table and the sector_max function.
REQ-032 Sub-module c1541_gcr_nib_dec: 5-bit code in -> 4-bit nibble plus invalid flag, combinational.

Verification
REQ-033 Reset, then 12 ones, then GCR(0x08) header for track 1 / sector 3 / id 0x41,0x42 with a correct cks. Expect sync_n low for bits 10-12 and hdr_valid=1.
REQ-034 Valid header, 8 gap bytes, SYNC, 0x07, data bytes 0x00..0xFF, correct cks. Expect 256 buf_we at addr 0x0300..0x03FF, sec_done with data_ok=1.
REQ-035 Same as REQ-034 with data cks flipped to 0x01. Expect data_ok=0, and with GCR_DEC_CKS_EN undefined expect data_ok=1.
REQ-036 Insert code 5'b00000 in data byte 10. Expect gcr_err=1, byte decoded as 0x00, data_ok=0, and gcr_err cleared at the next SYNC.
REQ-037 Header for track 18 arrives while the track input is 17. Expect hdr_valid=0, the following 0x07 block goes to HUNT, and no buf_we occurs.
REQ-038 SYNC arrives at data index 100. Expect no sec_done, writes stop at index 99, and the state is SYNC.
